// File: rtl/bank_switch_mux.sv
// Banked constant-set output mux with a runtime-writable register file
// and a handshaked bank switch that blanks the bundle during the change.
module bank_switch_mux #(
    parameter int WIDTH      = 3,
    parameter int NUM_CH     = 3,
    parameter int NUM_BANKS  = 3,
    parameter int GAP        = 1,
    parameter int RESET_BASE = 3,
    parameter int DEFAULT    = 0,
    localparam int BW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BW-1:0]           wr_bank,
    input  logic [CW-1:0]           wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    sel_valid,
    input  logic [BW-1:0]           sel_bank,
    output logic                    sel_ready,
    output logic                    sel_err,
    output logic [BW-1:0]           cur_bank,
    output logic                    out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data
);

    typedef enum logic {
        ACTIVE,
        BLANK
    } state_e;

    logic [WIDTH-1:0] bank_q [NUM_BANKS][NUM_CH];

    state_e         state_q, state_d;
    logic [GCW-1:0] cnt_q, cnt_d;
    logic [BW-1:0]  pend_q, pend_d;
    logic [BW-1:0]  cur_q, cur_d;
    logic           err_q, err_d;

    logic wr_ok;
    logic sel_ok;

    assign wr_ok  = (int'(wr_bank) < NUM_BANKS) && (int'(wr_ch) < NUM_CH);
    assign sel_ok = int'(sel_bank) < NUM_BANKS;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    bank_q[b][c] <= WIDTH'(RESET_BASE + b);
                end
            end
        end else if (wr_en && wr_ok) begin
            bank_q[wr_bank][wr_ch] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            pend_q  <= '0;
            cur_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        err_d   = 1'b0;
        unique case (state_q)
            ACTIVE: begin
                if (sel_valid) begin
                    if (!sel_ok) begin
                        err_d = 1'b1;
                    end else if (sel_bank != cur_q) begin
                        if (GAP == 0) begin
                            cur_d = sel_bank;
                        end else begin
                            pend_d  = sel_bank;
                            cnt_d   = GCW'(GAP);
                            state_d = BLANK;
                        end
                    end
                end
            end
            BLANK: begin
                // Counter holds the remaining blank cycles including this one
                cnt_d = cnt_q - GCW'(1);
                if (cnt_q == GCW'(1)) begin
                    cur_d   = pend_q;
                    state_d = ACTIVE;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    assign sel_ready = (state_q == ACTIVE);
    assign out_valid = (state_q == ACTIVE);
    assign sel_err   = err_q;
    assign cur_bank  = cur_q;

    always_comb begin
        out_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_q == BLANK) begin
                out_data[c*WIDTH +: WIDTH] = WIDTH'(DEFAULT);
            end else begin
                out_data[c*WIDTH +: WIDTH] = bank_q[cur_q][c];
            end
        end
    end

endmodule

// File: tb/tb_bank_switch_mux.sv
// Directed bench for bank_switch_mux; three builds (GAP=1, GAP=3, GAP=0)
// share one stimulus bus and each task checks the build it targets.
module tb_bank_switch_mux;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_bank;
    logic [1:0] wr_ch;
    logic [2:0] wr_data;
    logic       sel_valid;
    logic [1:0] sel_bank;

    logic       ready1, err1, ov1;
    logic [1:0] cur1;
    logic [8:0] od1;
    logic       ready3, err3, ov3;
    logic [1:0] cur3;
    logic [8:0] od3;
    logic       ready0, err0, ov0;
    logic [1:0] cur0;
    logic [8:0] od0;

    int checks;
    int failures;

    bank_switch_mux #(.GAP(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_ch(wr_ch), .wr_data(wr_data), .sel_valid(sel_valid),
        .sel_bank(sel_bank), .sel_ready(ready1), .sel_err(err1),
        .cur_bank(cur1), .out_valid(ov1), .out_data(od1)
    );

    bank_switch_mux #(.GAP(3)) dut3 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_ch(wr_ch), .wr_data(wr_data), .sel_valid(sel_valid),
        .sel_bank(sel_bank), .sel_ready(ready3), .sel_err(err3),
        .cur_bank(cur3), .out_valid(ov3), .out_data(od3)
    );

    bank_switch_mux #(.GAP(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_ch(wr_ch), .wr_data(wr_data), .sel_valid(sel_valid),
        .sel_bank(sel_bank), .sel_ready(ready0), .sel_err(err0),
        .cur_bank(cur0), .out_valid(ov0), .out_data(od0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_bank   = 2'd0;
        wr_ch     = 2'd0;
        wr_data   = 3'd0;
        sel_valid = 1'b0;
        sel_bank  = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (ov1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=1", ov1);
        end
        checks++;
        if (cur1 !== 2'd0) begin
            failures++;
            $display("FAIL reset_cur got=%0d exp=0", cur1);
        end
        checks++;
        if (od1 !== 9'o333) begin
            failures++;
            $display("FAIL reset_data got=%o exp=333", od1);
        end
        checks++;
        if (ready1 !== 1'b1 || err1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy_err got=%b%b exp=10", ready1, err1);
        end
        checks++;
        if (od3 !== 9'o333 || od0 !== 9'o333) begin
            failures++;
            $display("FAIL reset_data_other got=%o/%o exp=333/333", od3, od0);
        end
    endtask

    task automatic test_switch();
        do_reset();
        sel_valid = 1'b1;
        sel_bank  = 2'd2;
        tick();
        sel_valid = 1'b0;
        checks++;
        if (ov1 !== 1'b0 || ready1 !== 1'b0 || od1 !== 9'o000) begin
            failures++;
            $display("FAIL blank_out got=v%b r%b d%o exp=v0 r0 d000",
                     ov1, ready1, od1);
        end
        checks++;
        if (cur1 !== 2'd0) begin
            failures++;
            $display("FAIL blank_cur got=%0d exp=0", cur1);
        end
        checks++;
        if (ov0 !== 1'b1 || cur0 !== 2'd2 || od0 !== 9'o555) begin
            failures++;
            $display("FAIL gap0_switch got=v%b c%0d d%o exp=v1 c2 d555",
                     ov0, cur0, od0);
        end
        // write the pending bank while blanking
        wr_en   = 1'b1;
        wr_bank = 2'd2;
        wr_ch   = 2'd2;
        wr_data = 3'd1;
        tick();
        wr_en = 1'b0;
        checks++;
        if (ov1 !== 1'b1 || cur1 !== 2'd2) begin
            failures++;
            $display("FAIL switch_done got=v%b c%0d exp=v1 c2", ov1, cur1);
        end
        checks++;
        if (od1 !== 9'o155) begin
            failures++;
            $display("FAIL switch_data got=%o exp=155", od1);
        end
    endtask

    task automatic test_noop();
        do_reset();
        sel_valid = 1'b1;
        sel_bank  = 2'd0;
        tick();
        sel_valid = 1'b0;
        checks++;
        if (ov1 !== 1'b1 || ready1 !== 1'b1 || od1 !== 9'o333) begin
            failures++;
            $display("FAIL noop got=v%b r%b d%o exp=v1 r1 d333",
                     ov1, ready1, od1);
        end
    endtask

    task automatic test_write();
        do_reset();
        wr_en   = 1'b1;
        wr_bank = 2'd0;
        wr_ch   = 2'd1;
        wr_data = 3'd7;
        tick();
        checks++;
        if (od1 !== 9'o373) begin
            failures++;
            $display("FAIL write_active got=%o exp=373", od1);
        end
        wr_bank = 2'd3;
        wr_ch   = 2'd0;
        wr_data = 3'd1;
        tick();
        wr_bank = 2'd0;
        wr_ch   = 2'd3;
        wr_data = 3'd2;
        tick();
        wr_en = 1'b0;
        checks++;
        if (od1 !== 9'o373 || err1 !== 1'b0) begin
            failures++;
            $display("FAIL write_drop got=%o e%b exp=373 e0", od1, err1);
        end
        checks++;
        if (od0 !== 9'o373) begin
            failures++;
            $display("FAIL write_drop_gap0 got=%o exp=373", od0);
        end
    endtask

    task automatic test_sel_err();
        do_reset();
        sel_valid = 1'b1;
        sel_bank  = 2'd3;
        tick();
        sel_valid = 1'b0;
        checks++;
        if (err1 !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse got=%b exp=1", err1);
        end
        checks++;
        if (cur1 !== 2'd0 || ov1 !== 1'b1 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL err_state got=c%0d v%b r%b exp=c0 v1 r1",
                     cur1, ov1, ready1);
        end
        tick();
        checks++;
        if (err1 !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b exp=0", err1);
        end
    endtask

    task automatic test_gap3();
        int blanks;
        do_reset();
        sel_valid = 1'b1;
        sel_bank  = 2'd1;
        tick();
        // second request held during blanking must be ignored
        sel_bank = 2'd2;
        blanks   = 0;
        for (int i = 0; i < 10 && ov3 === 1'b0; i++) begin
            blanks++;
            if (blanks == 3) sel_valid = 1'b0;
            tick();
        end
        sel_valid = 1'b0;
        checks++;
        if (blanks != 3) begin
            failures++;
            $display("FAIL gap3_len got=%0d exp=3", blanks);
        end
        checks++;
        if (cur3 !== 2'd1 || od3 !== 9'o444 || ov3 !== 1'b1) begin
            failures++;
            $display("FAIL gap3_ignore got=c%0d d%o v%b exp=c1 d444 v1",
                     cur3, od3, ov3);
        end
        // abort a switch with reset, after dirtying bank 1
        sel_valid = 1'b1;
        sel_bank  = 2'd0;
        tick();
        sel_valid = 1'b0;
        wr_en   = 1'b1;
        wr_bank = 2'd1;
        wr_ch   = 2'd0;
        wr_data = 3'd7;
        tick();
        wr_en = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (cur3 !== 2'd0 || od3 !== 9'o333 || ov3 !== 1'b1) begin
            failures++;
            $display("FAIL gap3_rst got=c%0d d%o v%b exp=c0 d333 v1",
                     cur3, od3, ov3);
        end
        sel_valid = 1'b1;
        sel_bank  = 2'd1;
        tick();
        sel_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (ov3 !== 1'b0) begin
            failures++;
            $display("FAIL gap3_blank3 got=%b exp=0", ov3);
        end
        tick();
        checks++;
        if (cur3 !== 2'd1 || od3 !== 9'o444) begin
            failures++;
            $display("FAIL gap3_bank1 got=c%0d d%o exp=c1 d444", cur3, od3);
        end
    endtask

    task automatic test_gap0_write();
        do_reset();
        sel_valid = 1'b1;
        sel_bank  = 2'd1;
        wr_en     = 1'b1;
        wr_bank   = 2'd1;
        wr_ch     = 2'd0;
        wr_data   = 3'd6;
        tick();
        idle_inputs();
        checks++;
        if (ov0 !== 1'b1 || cur0 !== 2'd1 || od0 !== 9'o446) begin
            failures++;
            $display("FAIL gap0_wr got=v%b c%0d d%o exp=v1 c1 d446",
                     ov0, cur0, od0);
        end
        checks++;
        if (ready0 !== 1'b1) begin
            failures++;
            $display("FAIL gap0_ready got=%b exp=1", ready0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_switch();
        test_noop();
        test_write();
        test_sel_err();
        test_gap3();
        test_gap0_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bank_switch_mux.md
Name: bank_switch_mux

Overview:
- Parametrised successor to the fixed two-bank case-select output mux: NUM_BANKS banks of NUM_CH channel registers, each WIDTH bits; one bank is driven onto the output bundle at a time.
- Banks are runtime-writable through a single write port.
- Bank changes are requested through a valid/ready handshake and include a programmable blanking interval, so downstream logic never sees a mixed or glitching bundle.
- Sits between configuration/control logic and datapath consumers that need a selectable constant set.

Parameters:
- WIDTH, 3: bits per channel.
- NUM_CH, 3: channels per bank.
- NUM_BANKS, 3: number of banks (>=2).
- GAP, 1: blanking cycles on a bank change (0 allowed).
- RESET_BASE, 3: reset value of every channel in bank b is (RESET_BASE+b) mod 2^WIDTH.
- DEFAULT, 0: per-channel value driven while blanking.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_bank  in  BW  target bank for the write; BW = max(1, clog2(NUM_BANKS)).
- wr_ch  in  CW  target channel for the write; CW = max(1, clog2(NUM_CH)).
- wr_data  in  WIDTH  write data.
- sel_valid  in  1  bank-change request.
- sel_bank  in  BW  requested bank.
- sel_ready  out  1  high when a request can be accepted.
- sel_err  out  1  one-cycle pulse when an out-of-range request is rejected.
- cur_bank  out  BW  currently selected bank.
- out_valid  out  1  out_data holds a stable bank image.
- out_data  out  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].

Behaviour:
- Reset: already decided as synchronous active-high rst on clk. Reset applies on any clk edge with rst=1, in any state.
  - Bank b channels load (RESET_BASE+b) mod 2^WIDTH.
  - cur_bank=0, FSM=ACTIVE, blank counter=0, sel_err=0.
  - Outputs after reset: out_valid=1, sel_ready=1, out_data = bank 0 image (3,3,3 with defaults).
  - Reset during BLANK aborts the switch; the pending bank is discarded.
- FSM states: ACTIVE and BLANK.
- ACTIVE:
  - sel_ready=1 and out_valid=1.
  - out_data is a combinational mux of the bank[cur_bank] registers.
- BLANK:
  - sel_ready=0 and out_valid=0.
  - out_data = DEFAULT replicated on every channel.
  - cur_bank still shows the old bank.
- Handshake: a request is accepted on an edge where sel_valid && sel_ready.
  - sel_bank >= NUM_BANKS: rejected; sel_err=1 for the following cycle; no other state change.
  - sel_bank == cur_bank: accepted as a no-op; no blanking.
  - Different bank and GAP=0: cur_bank updates at the accepting edge; stays ACTIVE; new image visible the next cycle.
  - Different bank and GAP>0: latch pending bank, load counter=GAP, go to BLANK.
    - Each BLANK cycle decrements the counter.
    - On the edge where the counter reaches 0: cur_bank <= pending, go to ACTIVE.
    - Result: exactly GAP cycles have out_valid=0.
- sel_valid while sel_ready=0 is ignored, not queued; the requester must hold or re-issue.
- Writes:
  - On an edge with wr_en=1, bank[wr_bank][wr_ch] <= wr_data. Writes are accepted in any FSM state.
  - A write to the active bank appears on out_data in the cycle after the edge.
  - A write to the pending bank during BLANK is visible when ACTIVE resumes.
  - Writes with wr_bank >= NUM_BANKS or wr_ch >= NUM_CH are dropped silently, without setting sel_err.
- Simultaneous write and accepted select on the same edge: both take effect. The new bank image includes the write.
- Arithmetic is width-exact; the blank counter is clog2(GAP+1) bits; no wrap-around paths exist.

Test Plan:
- Reset then idle -> out_valid=1, cur_bank=0, out_data channels = 3,3,3; sel_ready=1.
- sel_valid with sel_bank=2, GAP=1 -> one cycle of out_valid=0 and out_data=0,0,0; then cur_bank=2 and out_data=5,5,5.
- Write bank0 ch1 = 7 while bank 0 is active -> next cycle out_data = 3,7,3. Write wr_bank=3 -> no change anywhere.
- sel_bank=3 -> sel_err pulses for exactly one cycle; cur_bank and out_valid are unchanged.
- GAP=3 build: request bank 1, assert a second request and a reset mid-BLANK -> the second request is ignored while BLANK. After the reset, cur_bank=0, out_data=3,3,3 and bank 1 reads 4 again.
- GAP=0 build: request bank 1 with a simultaneous write of 6 to bank 1 ch0 -> next cycle out_valid=1 and out_data = 6,4,4.
